iprefetch_buffer: RTL and testbench
===================================

Name: iprefetch_buffer

Overview:
Single-entry next-line stream buffer. It sits between the L1 instruction cache's refill port and the shared line memory.
- Cache side: looks like memory to the I-cache (level read request, one-cycle ready pulse, 128-bit line).
- Memory side: looks like the I-cache to memory.
- After every line delivered to the cache, it prefetches the sequentially next line. A following sequential miss is then served in 1 cycle instead of a full memory round trip.

Parameters:
PF_EN, 1, 1 = prefetch next line after each delivery; 0 = pure pass-through (buffer never fills).
CNT_W, 16, width of saturating performance counters.

Ports:
clk  input  1  clock, all state on rising edge.
proc_reset  input  1  asynchronous, active-high reset.
cache_read  input  1  refill request from I-cache; held high until cache_ready seen.
cache_addr  input  30  word address of request; line address = cache_addr[29:2], [1:0] ignored.
cache_rdata  output  128  line data to I-cache; valid while cache_ready=1.
cache_ready  output  1  one-cycle pulse, line delivered.
mem_read  output  1  request to memory; held high until mem_ready.
mem_addr  output  30  memory word address, always {line,2'b00}.
mem_rdata  input  128  line from memory, valid with mem_ready.
mem_ready  input  1  one-cycle pulse, memory line returned.
mem_write  output  1  tied 0.
pf_hits  output  CNT_W  requests served from buffer, saturating.
demand_miss  output  CNT_W  requests forwarded to memory, saturating.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; mem_read=0; mem_addr=0; cache_ready=0; cache_rdata=0; buf_valid=0; buf_line=0; buf_data=0; both counters=0. A mem_ready arriving after reset is ignored.
- State register: buf_valid, buf_line[27:0], buf_data[127:0], pf_line[27:0].
- Four states: IDLE, DEMAND, PREF, RESP.
- IDLE, cache_read=1, buf_valid and buf_line==cache_addr[29:2] (hit):
  - load cache_rdata=buf_data; next state RESP; pf_hits++.
  - request-to-ready latency = 1 cycle.
- IDLE, cache_read=1, miss:
  - buf_valid<=0; mem_read<=1; mem_addr<={cache_addr[29:2],2'b00}; next state DEMAND; demand_miss++.
- IDLE, cache_read=0: hold; ignore mem_ready.
- DEMAND: wait for mem_ready. On mem_ready: mem_read<=0; cache_rdata<=mem_rdata; next state RESP. The demanded line is not stored in the buffer.
- RESP: cache_ready=1 for exactly this cycle. pf_line<=served line+1, mod 2^28 (line 0x0FFFFFFF wraps to 0).
  - PF_EN=1: mem_read<=1, mem_addr<={pf_line,2'b00}, next state PREF.
  - PF_EN=0: next state IDLE.
- PREF: wait for mem_ready. On mem_ready: mem_read<=0; buf_data<=mem_rdata; buf_line<=pf_line; buf_valid<=1.
  - If cache_read=1 and cache_addr[29:2]==pf_line on that same cycle: also cache_rdata<=mem_rdata; count as pf_hits; next state RESP (chains the next prefetch).
  - Otherwise: next state IDLE. Any pending non-matching request is then handled by IDLE on the following cycle. No abort of in-flight memory reads.
- cache_read rising during PREF before mem_ready: no action until mem_ready.
- mem_read is always low for at least 1 cycle between consecutive memory requests.
- Simultaneous mem_ready and reset: reset wins.
- Counters stop at all-ones.

Test Plan:
1. Cold miss: cache_read, cache_addr=0x010; memory returns D0 3 cycles after mem_read.
   -> mem_addr=0x010; cache_ready pulses 1 cycle after mem_ready with D0.
   -> next cycle mem_read=1, mem_addr=0x014; demand_miss=1.
2. Sequential hit: after (1) prefetch returns D1, drive cache_read, cache_addr=0x015.
   -> cache_ready=1 with D1 on the next cycle; no memory request for 0x014.
   -> then mem_addr=0x018; pf_hits=1.
3. Request during matching prefetch: cache_read with addr 0x018 while PREF 0x018 is in flight.
   -> cache_ready 1 cycle after mem_ready with that data; next prefetch 0x01C.
4. Non-matching request during prefetch: cache_read with addr 0x100 while PREF 0x01C is in flight.
   -> buffer fills with 0x01C line; one idle cycle; mem_addr=0x100 demand; buf_valid=0; demand_miss++.
5. Wrap: miss at cache_addr=0x3FFFFFFC. -> after delivery, prefetch mem_addr=0x00000000.
6. Reset mid-DEMAND: assert proc_reset.
   -> mem_read and cache_ready low immediately; counters 0; late mem_ready ignored.
   -> next request is treated as a miss.

Source files
------------

// File: rtl/iprefetch_buffer.sv
// Single-entry next-line stream buffer between the I-cache refill port and line memory.
// After each delivered line it fetches the following line so a sequential miss is served in one cycle.
module iprefetch_buffer #(
   parameter bit PF_EN = 1'b1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             proc_reset,
   input  logic             cache_read,
   input  logic [29:0]      cache_addr,
   output logic [127:0]     cache_rdata,
   output logic             cache_ready,
   output logic             mem_read,
   output logic [29:0]      mem_addr,
   input  logic [127:0]     mem_rdata,
   input  logic             mem_ready,
   output logic             mem_write,
   output logic [CNT_W-1:0] pf_hits,
   output logic [CNT_W-1:0] demand_miss
);

   typedef enum logic [1:0] {
      IDLE,
      DEMAND,
      PREF,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic               mem_read_q, mem_read_d;
   logic [29:0]        mem_addr_q, mem_addr_d;
   logic               cache_ready_q, cache_ready_d;
   logic [127:0]       cache_rdata_q, cache_rdata_d;
   logic               buf_valid_q, buf_valid_d;
   logic [27:0]        buf_line_q, buf_line_d;
   logic [127:0]       buf_data_q, buf_data_d;
   logic [27:0]        pf_line_q, pf_line_d;
   logic [CNT_W-1:0]   pf_hits_q, pf_hits_d;
   logic [CNT_W-1:0]   demand_miss_q, demand_miss_d;

   logic [27:0]        req_line;
   logic               addr_unused;

   assign req_line    = cache_addr[29:2];
   assign addr_unused = ^cache_addr[1:0];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // pf_line is advanced on entry to RESP so the prefetch address is ready in RESP itself.
   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_addr_d    = mem_addr_q;
      cache_rdata_d = cache_rdata_q;
      buf_valid_d   = buf_valid_q;
      buf_line_d    = buf_line_q;
      buf_data_d    = buf_data_q;
      pf_line_d     = pf_line_q;
      pf_hits_d     = pf_hits_q;
      demand_miss_d = demand_miss_q;

      case (state_q)
         IDLE: begin
            if (cache_read) begin
               if (buf_valid_q && (buf_line_q == req_line)) begin
                  cache_rdata_d = buf_data_q;
                  pf_line_d     = req_line + 28'd1;
                  pf_hits_d     = sat_inc(pf_hits_q);
                  state_d       = RESP;
               end else begin
                  buf_valid_d   = 1'b0;
                  mem_read_d    = 1'b1;
                  mem_addr_d    = {req_line, 2'b00};
                  demand_miss_d = sat_inc(demand_miss_q);
                  state_d       = DEMAND;
               end
            end
         end
         DEMAND: begin
            if (mem_ready) begin
               mem_read_d    = 1'b0;
               cache_rdata_d = mem_rdata;
               pf_line_d     = mem_addr_q[29:2] + 28'd1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (PF_EN) begin
               mem_read_d = 1'b1;
               mem_addr_d = {pf_line_q, 2'b00};
               state_d    = PREF;
            end else begin
               state_d    = IDLE;
            end
         end
         PREF: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               buf_data_d  = mem_rdata;
               buf_line_d  = pf_line_q;
               buf_valid_d = 1'b1;
               // A request already waiting for this very line is answered straight from memory data.
               if (cache_read && (req_line == pf_line_q)) begin
                  cache_rdata_d = mem_rdata;
                  pf_line_d     = pf_line_q + 28'd1;
                  pf_hits_d     = sat_inc(pf_hits_q);
                  state_d       = RESP;
               end else begin
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cache_ready_d = (state_d == RESP);
   end

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q       <= IDLE;
         mem_read_q    <= 1'b0;
         mem_addr_q    <= '0;
         cache_ready_q <= 1'b0;
         cache_rdata_q <= '0;
         buf_valid_q   <= 1'b0;
         buf_line_q    <= '0;
         buf_data_q    <= '0;
         pf_line_q     <= '0;
         pf_hits_q     <= '0;
         demand_miss_q <= '0;
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_addr_q    <= mem_addr_d;
         cache_ready_q <= cache_ready_d;
         cache_rdata_q <= cache_rdata_d;
         buf_valid_q   <= buf_valid_d;
         buf_line_q    <= buf_line_d;
         buf_data_q    <= buf_data_d;
         pf_line_q     <= pf_line_d;
         pf_hits_q     <= pf_hits_d;
         demand_miss_q <= demand_miss_d;
      end
   end

   assign cache_rdata = cache_rdata_q;
   assign cache_ready = cache_ready_q;
   assign mem_read    = mem_read_q;
   assign mem_addr    = mem_addr_q;
   assign mem_write   = 1'b0;
   assign pf_hits     = pf_hits_q;
   assign demand_miss = demand_miss_q;

endmodule

// File: tb/tb_iprefetch_buffer.sv
// Scoreboard bench for iprefetch_buffer: a cache-side driver, a randomized memory responder
// and a monitor that checks every delivered line against a line-level model of the stream buffer.
module tb_iprefetch_buffer;

   logic         clk = 1'b0;
   logic         proc_reset;
   logic         cache_read;
   logic [29:0]  cache_addr;
   logic [127:0] cache_rdata;
   logic         cache_ready;
   logic         mem_read;
   logic [29:0]  mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         mem_write;
   logic [15:0]  pf_hits;
   logic [15:0]  demand_miss;

   always #5 clk = ~clk;

   iprefetch_buffer #(.PF_EN(1'b1), .CNT_W(16)) dut (
      .clk         (clk),
      .proc_reset  (proc_reset),
      .cache_read  (cache_read),
      .cache_addr  (cache_addr),
      .cache_rdata (cache_rdata),
      .cache_ready (cache_ready),
      .mem_read    (mem_read),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .mem_write   (mem_write),
      .pf_hits     (pf_hits),
      .demand_miss (demand_miss)
   );

   typedef struct {
      logic [127:0] data;
      int unsigned  hits;
      int unsigned  misses;
      int           issueCycle;
      bit           checkLat;
   } exp_t;

   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          memFixedLat = -1;
   bit          memBusy = 1'b0;

   // Line-level model: the buffer always ends up holding (last served line + 1).
   bit          haveNext = 1'b0;
   logic [27:0] nextLine = '0;
   int unsigned modelHits = 0;
   int unsigned modelMisses = 0;

   function automatic logic [127:0] lineData(input logic [27:0] l);
      return {4'hA, l, 4'h5, ~l, 4'hC, l + 28'd7, 4'h3, l ^ 28'h5A5A5A5};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   // Memory responder: random latency unless a fixed one is forced.
   initial begin
      logic [29:0] reqAddr;
      int          lat;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_read && !proc_reset) begin
            memBusy = 1'b1;
            reqAddr = mem_addr;
            checkOutput("mem_addr_align", 128'(mem_addr[1:0]), 128'(0));
            lat = (memFixedLat >= 0) ? memFixedLat : int'($urandom_range(0, 4));
            repeat (lat) begin @(posedge clk); #1; end
            mem_rdata = lineData(reqAddr[29:2]);
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            checkOutput("mem_read_gap", 128'(mem_read), 128'(0));
            memBusy = 1'b0;
         end
      end
   end

   // Monitor: every cache_ready pops one expected delivery.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!proc_reset && cache_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ready: cache_ready=1, required 0 with no request pending");
            end else begin
               e = expQ.pop_front();
               checkOutput("cache_rdata", cache_rdata, e.data);
               checkOutput("pf_hits", 128'(pf_hits), 128'(e.hits));
               checkOutput("demand_miss", 128'(demand_miss), 128'(e.misses));
               if (e.checkLat)
                  checkOutput("hit_latency", 128'(cycle - e.issueCycle), 128'(1));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [29:0] addr, input int gap);
      exp_t        e;
      logic [27:0] line;
      bit          hit;
      bit          done;
      int          waited;
      repeat (gap) begin @(posedge clk); #1; end
      line = addr[29:2];
      hit  = haveNext && (line == nextLine);
      if (hit) modelHits++;
      else     modelMisses++;
      e.data       = lineData(line);
      e.hits       = modelHits;
      e.misses     = modelMisses;
      e.issueCycle = cycle;
      e.checkLat   = hit && (gap >= 8);
      expQ.push_back(e);
      nextLine   = line + 28'd1;
      haveNext   = 1'b1;
      cache_addr = addr;
      cache_read = 1'b1;
      done   = 1'b0;
      waited = 0;
      while (!done && waited < 300) begin
         @(posedge clk); #1;
         waited++;
         if (cache_ready) done = 1'b1;
      end
      cache_read = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout: no cache_ready for addr %0h, required within 300 cycles", addr);
         expQ.delete();
      end
   endtask

   task automatic resetModel();
      haveNext    = 1'b0;
      modelHits   = 0;
      modelMisses = 0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [29:0] addr;
      int          r;
      int          waited;
      bit          quiet;

      proc_reset = 1'b1;
      cache_read = 1'b0;
      cache_addr = '0;
      #2;
      checkOutput("reset_cache_ready", 128'(cache_ready), 128'(0));
      checkOutput("reset_mem_read", 128'(mem_read), 128'(0));
      checkOutput("reset_mem_addr", 128'(mem_addr), 128'(0));
      checkOutput("reset_cache_rdata", cache_rdata, 128'(0));
      checkOutput("reset_counters", 128'({pf_hits, demand_miss}), 128'(0));
      checkOutput("mem_write", 128'(mem_write), 128'(0));
      repeat (3) @(posedge clk);
      #3 proc_reset = 1'b0;

      // Directed walk: cold miss, settled hit, in-flight hit, non-matching request, wrap.
      applyStimulus(30'h010, 1);
      applyStimulus(30'h015, 10);
      applyStimulus(30'h018, 0);
      applyStimulus(30'h100, 0);
      applyStimulus(30'h3FFFFFFC, 2);
      applyStimulus(30'h000, 0);

      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 3));
         if (r < 2)       addr = {nextLine, 2'($urandom)};
         else if (r == 2) addr = 30'($urandom_range(0, 63));
         else             addr = 30'($urandom);
         applyStimulus(addr, int'($urandom_range(0, 10)));
      end

      // Reset while a demand read is outstanding; the late mem_ready must be ignored.
      repeat (10) @(posedge clk);
      #1;
      memFixedLat = 8;
      cache_addr  = 30'h2000;
      cache_read  = 1'b1;
      waited = 0;
      while (!mem_read && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("demand_issued", 128'(mem_read), 128'(1));
      repeat (2) begin @(posedge clk); #1; end
      proc_reset = 1'b1;
      #1;
      checkOutput("async_reset_mem_read", 128'(mem_read), 128'(0));
      checkOutput("async_reset_ready", 128'(cache_ready), 128'(0));
      checkOutput("async_reset_counters", 128'({pf_hits, demand_miss}), 128'(0));
      cache_read = 1'b0;
      resetModel();
      @(posedge clk); #1;
      proc_reset = 1'b0;
      quiet = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
         if (mem_read || cache_ready) quiet = 1'b0;
      end
      checkOutput("late_ready_ignored", 128'(quiet), 128'(1));
      waited = 0;
      while (memBusy && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      memFixedLat = -1;

      applyStimulus(30'h2000, 0);
      applyStimulus(30'h2004, 10);

      // Reset with a valid buffer in IDLE: the buffered line must not hit afterwards.
      repeat (10) begin @(posedge clk); #1; end
      proc_reset = 1'b1;
      #2;
      proc_reset = 1'b0;
      resetModel();
      applyStimulus(30'h2008, 2);
      applyStimulus(30'h200C, 10);

      repeat (5) @(posedge clk);
      checkOutput("queue_empty", 128'(expQ.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
